// File: rtl/seq_neuron.sv
`default_nettype none
// ============================================================================
// Module   : seq_neuron
// Purpose  : Time-multiplexed perceptron neuron. Serially accepts N_INPUTS
//            sign-magnitude samples, multiplies each by a runtime-writable
//            weight, accumulates, adds the bias term and emits the saturated
//            sign-magnitude sum plus a step activation.
// Ports    : clk, rst_n                    - clock, async active-low reset
//            w_we, w_addr, w_data          - weight RAM write port
//                                            (addr N_INPUTS = bias weight)
//            in_valid, in_ready, in_data   - sample stream
//            out_valid, out_ready          - result stream handshake
//            out_sum, out_act              - saturated sum, activation
// Revision : 1.0 - initial release
// ============================================================================
module seq_neuron #(
  parameter int N_INPUTS = 2,
  parameter int BIAS     = 1,
  parameter int SIGN     = 1,
  parameter int Q_M      = 15,
  parameter int Q_N      = 16,
  localparam int W       = SIGN + Q_M + Q_N,
  localparam int AW      = $clog2(N_INPUTS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          w_we,
  input  logic [AW-1:0] w_addr,
  input  logic [W-1:0]  w_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_sum,
  output logic          out_act
);

  // Accumulator is wide enough that N_INPUTS+1 saturated terms never overflow.
  localparam int ACC_W = W + AW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_INPUTS - 1);
  localparam logic [AW-1:0] BIAS_IDX = AW'(N_INPUTS);
  localparam logic [W-2:0]  MAG_MAX  = '1;
  localparam logic signed [ACC_W-1:0] ACC_MAX =
    $signed({{(ACC_W-W+1){1'b0}}, MAG_MAX});

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_BIAS = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]            weights [0:N_INPUTS];
  logic [AW-1:0]           count;
  logic signed [ACC_W-1:0] acc;

  // Sign-magnitude to two's complement; a negative zero collapses to 0.
  function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic neg,
                                                       input logic [W-2:0] mag);
    logic signed [ACC_W-1:0] ext;
    ext = $signed({{(ACC_W-W+1){1'b0}}, mag});
    return neg ? -ext : ext;
  endfunction

  // --------------------------------------------------------------------------
  // Multiplier: combinational read of the current weight, so a write landing
  // on the same edge as the sample does not affect this product.
  // --------------------------------------------------------------------------
  logic [W-1:0]            cur_w;
  logic [2*W-3:0]          prod_full;
  logic [2*W-3:0]          prod_shift;
  logic [W-2:0]            prod_mag;
  logic signed [ACC_W-1:0] prod_tc;

  assign cur_w = weights[count];

  always_comb begin
    prod_full  = {{(W-1){1'b0}}, in_data[W-2:0]} * {{(W-1){1'b0}}, cur_w[W-2:0]};
    prod_shift = prod_full >> Q_N;
    if (prod_shift > {{(W-1){1'b0}}, MAG_MAX}) begin
      prod_mag = MAG_MAX;
    end else begin
      prod_mag = prod_shift[W-2:0];
    end
    prod_tc = sm_to_tc(in_data[W-1] ^ cur_w[W-1], prod_mag);
  end

  // --------------------------------------------------------------------------
  // Bias term and output conversion
  // --------------------------------------------------------------------------
  logic [W-1:0]            bias_word;
  logic signed [ACC_W-1:0] bias_tc;
  logic signed [ACC_W-1:0] acc_final;
  logic signed [ACC_W-1:0] acc_abs;
  logic [W-2:0]            sum_mag;
  logic [W-1:0]            sum_nxt;
  logic                    act_nxt;

  generate
    if (BIAS != 0) begin : g_bias_on
      assign bias_word = weights[BIAS_IDX];
    end else begin : g_bias_off
      assign bias_word = '0;
    end
  endgenerate

  assign bias_tc   = sm_to_tc(bias_word[W-1], bias_word[W-2:0]);
  assign acc_final = acc + bias_tc;

  always_comb begin
    acc_abs = acc_final[ACC_W-1] ? -acc_final : acc_final;
    if (acc_abs > ACC_MAX) begin
      sum_mag = MAG_MAX;
    end else begin
      sum_mag = acc_abs[W-2:0];
    end
    // Sign only set for a nonzero magnitude so -0 is never emitted.
    sum_nxt = {acc_final[ACC_W-1] && (sum_mag != '0), sum_mag};
    act_nxt = !acc_final[ACC_W-1] && (acc_final != '0);
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  logic take;
  assign take = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && (count == LAST_IDX)) begin
          state_nxt = ST_BIAS;
        end
      end
      ST_BIAS: begin
        state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_nxt = ST_ACC;
        end
      end
      default: begin
        state_nxt = ST_ACC;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and weight RAM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_act   <= 1'b0;
      for (int i = 0; i <= N_INPUTS; i++) begin
        weights[i] <= '0;
      end
    end else begin
      if (w_we && (w_addr <= BIAS_IDX)) begin
        weights[w_addr] <= w_data;
      end
      case (state)
        ST_ACC: begin
          if (take) begin
            acc   <= acc + prod_tc;
            count <= (count == LAST_IDX) ? '0 : count + 1'b1;
          end
        end
        ST_BIAS: begin
          acc       <= acc_final;
          out_sum   <= sum_nxt;
          out_act   <= act_nxt;
          out_valid <= 1'b1;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
